// File: rtl/cdc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cdc_pkg
// Description : Shared types for the toggle req/ack clock-domain-crossing
//               handshake (transmitter now, receiver later).
// Contents    : tx_state_e - transmitter FSM state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package cdc_pkg;

  typedef enum logic [0:0] {
    TX_IDLE     = 1'b0,
    TX_WAIT_ACK = 1'b1
  } tx_state_e;

endpackage
`default_nettype wire

// File: rtl/synchronizer_2ff.sv
`default_nettype none
// ============================================================================
// Module      : synchronizer_2ff
// Description : Two-flop synchronizer bringing an asynchronous level into the
//               clk_i domain. Only the first stage may go metastable.
// Ports       : clk_i  - destination clock
//               rst_ni - reset, active-low, sampled on clk_i
//               d_i    - asynchronous input
//               q_o    - synchronized output (two clk_i edges of latency)
// Revision    : 1.0 - initial release
// ============================================================================
module synchronizer_2ff #(
  parameter int DATA_WIDTH = 1
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic [DATA_WIDTH-1:0] d_i,
  output logic [DATA_WIDTH-1:0] q_o
);

  logic [DATA_WIDTH-1:0] stage0;
  logic [DATA_WIDTH-1:0] stage1;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      stage0 <= '0;
      stage1 <= '0;
    end else begin
      stage0 <= d_i;
      stage1 <= stage0;
    end
  end

  assign q_o = stage1;

endmodule
`default_nettype wire

// File: rtl/cdc_handshake_tx.sv
`default_nettype none
// ============================================================================
// Module      : cdc_handshake_tx
// Description : Source side of a two-phase (toggle) req/ack handshake that
//               moves a DATA_WIDTH word into another clock domain.
// Ports       : clk_i          - source-domain clock
//               rst_i          - synchronous active-high reset
//               valid_i/data_i - word offered by the source
//               ready_o        - high when a word can be accepted
//               xfer_req_o     - request toggle to destination (registered)
//               xfer_data_o    - captured word, stable while req outstanding
//               xfer_ack_i     - ack toggle from destination (asynchronous)
//               xfer_cnt_o     - completed transfers, wraps
//               protocol_err_o - sticky: ack moved with no request pending
// Revision    : 1.0 - initial release
// ============================================================================
module cdc_handshake_tx
  import cdc_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  valid_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  output logic                  ready_o,
  output logic                  xfer_req_o,
  output logic [DATA_WIDTH-1:0] xfer_data_o,
  input  logic                  xfer_ack_i,
  output logic [CNT_WIDTH-1:0]  xfer_cnt_o,
  output logic                  protocol_err_o
);

  tx_state_e             state;
  tx_state_e             state_next;
  logic                  req_q;
  logic [DATA_WIDTH-1:0] data_q;
  logic [CNT_WIDTH-1:0]  cnt_q;
  logic                  err_q;
  logic                  ack_sync;
  logic                  rst_n;
  logic                  accept;
  logic                  complete;
  logic                  err_set;

  assign rst_n = ~rst_i;

  // The ack is the only signal crossing into this domain.
  synchronizer_2ff #(
    .DATA_WIDTH (1)
  ) u_ack_sync (
    .clk_i  (clk_i),
    .rst_ni (rst_n),
    .d_i    (xfer_ack_i),
    .q_o    (ack_sync)
  );

  // Next-state logic. A transfer is done once the returned ack toggle level
  // matches the request level we sent.
  always_comb begin
    state_next = state;
    accept     = 1'b0;
    complete   = 1'b0;
    case (state)
      TX_IDLE: begin
        if (valid_i) begin
          accept     = 1'b1;
          state_next = TX_WAIT_ACK;
        end
      end
      TX_WAIT_ACK: begin
        if (ack_sync == req_q) begin
          complete   = 1'b1;
          state_next = TX_IDLE;
        end
      end
      default: state_next = TX_IDLE;
    endcase
  end

  // While idle the ack must already agree with the request level; any
  // disagreement means the destination toggled without being asked.
  assign err_set = (state == TX_IDLE) && (ack_sync != req_q);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state  <= TX_IDLE;
      req_q  <= 1'b0;
      data_q <= '0;
      cnt_q  <= '0;
      err_q  <= 1'b0;
    end else begin
      state <= state_next;
      // Data only changes together with the request toggle, so the
      // destination may sample it without per-bit synchronization.
      if (accept) begin
        req_q  <= ~req_q;
        data_q <= data_i;
      end
      if (complete) begin
        cnt_q <= cnt_q + CNT_WIDTH'(1);
      end
      if (err_set) begin
        err_q <= 1'b1;
      end
    end
  end

  assign ready_o        = (state == TX_IDLE);
  assign xfer_req_o     = req_q;
  assign xfer_data_o    = data_q;
  assign xfer_cnt_o     = cnt_q;
  assign protocol_err_o = err_q;

endmodule
`default_nettype wire

// File: doc/cdc_handshake_tx.md
# cdc_handshake_tx

Source-side transmitter of a two-phase (toggle) req/ack handshake for moving a multi-bit word into another clock domain. It accepts a word on a valid/ready port, holds it stable on `xfer_data_o`, toggles `xfer_req_o`, then waits for the destination's toggled ack to return through a 2-FF synchronizer before accepting the next word. It sits in the source clock domain; the destination-side receiver synchronizes `xfer_req_o` and samples `xfer_data_o`.

## Interface
- `DATA_WIDTH`, 8: width of transferred word.
- `CNT_WIDTH`, 16: width of completed-transfer counter.
- `clk_i`  in  1  source-domain clock.
- `rst_i`  in  1  reset, synchronous, active-high.
- `valid_i`  in  1  source has a word.
- `data_i`  in  DATA_WIDTH  word to transfer.
- `ready_o`  out  1  block can accept a word; handshake completes when `valid_i && ready_o` at a rising edge.
- `xfer_req_o`  out  1  request toggle to destination; registered.
- `xfer_data_o`  out  DATA_WIDTH  captured word; registered, stable whenever a request is outstanding.
- `xfer_ack_i`  in  1  ack toggle from destination; asynchronous to `clk_i`.
- `xfer_cnt_o`  out  CNT_WIDTH  number of completed transfers, wraps modulo 2^CNT_WIDTH.
- `protocol_err_o`  out  1  sticky: ack toggled while no request outstanding.

## Operation
- FSM states: `TX_IDLE`, `TX_WAIT_ACK`. `ready_o = (state == TX_IDLE)`, combinational from state only.
- `TX_IDLE`, `valid_i` high: capture `data_i` into `xfer_data_o`, invert `req_q` (`xfer_req_o`), go to `TX_WAIT_ACK`.
- `TX_IDLE`, `valid_i` low: hold all state.
- `TX_WAIT_ACK`: `xfer_data_o` and `xfer_req_o` frozen; `valid_i`/`data_i` ignored. When `ack_sync == req_q`: go to `TX_IDLE`, increment `xfer_cnt_o` by 1 (wraps from all-ones to 0).
- `ack_sync` is `xfer_ack_i` after two `clk_i` flops; no other logic touches `xfer_ack_i`.
- Error: in `TX_IDLE`, `ack_sync != req_q` sets `protocol_err_o`. It clears only on reset. The FSM is otherwise unaffected: the next accepted word still toggles the request.
- Reset values:
  - `state = TX_IDLE`, `ready_o = 1`.
  - `xfer_req_o = 0`, `xfer_data_o = 0`.
  - `xfer_cnt_o = 0`, `protocol_err_o = 0`.
  - Both synchronizer flops = 0.
- Reset mid-transfer abandons the outstanding request: `xfer_req_o` returns to 0. The destination must be reset in the same window so its ack also returns to 0; otherwise `protocol_err_o` flags the mismatch.

## Timing
- Accept at edge N: `xfer_req_o` and `xfer_data_o` update at N; `ready_o` is low from N.
- `xfer_data_o` changes at the same edge as `xfer_req_o` and at no other time. The destination samples it only after seeing the synchronized req edge, so data is multi-cycle stable (no per-bit synchronization).
- Ack return: `xfer_ack_i` change first sampled at edge A. `ack_sync` valid after edge A+1. State returns to `TX_IDLE` and the counter increments at A+2; `ready_o` is high from A+2.
- Simultaneous completion and `valid_i`: not accepted in the completing cycle (`ready_o` is 0). Accepted at the next edge if still valid.
- Minimum source-side cycle per word: 1 accept edge + 2 synchronizer edges + 1 completion edge + destination round trip.
- Metastability is confined to synchronizer stage 0.

## Structure
- Shared package `cdc_pkg` holds `typedef enum logic [0:0] {TX_IDLE, TX_WAIT_ACK} tx_state_e`. The receiver's future state enum also goes here.
- One sub-module: the existing `synchronizer_2ff` with `DATA_WIDTH = 1` for `xfer_ack_i`.
  - Its `rst_ni` is driven by `~rst_i`.
  - `rst_i` must be held at least one `clk_i` cycle, which already holds for a synchronous reset.
- Everything else (FSM, data register, counter, error flag) lives in `cdc_handshake_tx`.

## Test plan
- **Reset:** assert `rst_i` 2 cycles → `ready_o = 1`, `xfer_req_o = 0`, `xfer_data_o = 0`, `xfer_cnt_o = 0`, `protocol_err_o = 0`.
- **Single transfer:** `valid_i = 1`, `data_i = 0xA5` at edge N → `xfer_req_o = 1`, `xfer_data_o = 0xA5`, `ready_o = 0` after N. Bench toggles `xfer_ack_i` to 1, first sampled at A → `ready_o = 1` and `xfer_cnt_o = 1` exactly at A+2.
- **Stall:** in `TX_WAIT_ACK`, drive `data_i = 0x3C` with `valid_i = 1` for 10 cycles, no ack → `xfer_data_o` stays 0xA5, `xfer_req_o` stays 1, `xfer_cnt_o` unchanged.
- **Back-to-back:** `valid_i` held high with data 0x01..0x04, model receiver acks each after 3 cycles → four req toggles (1,0,1,0), data sequence 0x01..0x04, `xfer_cnt_o = 4`.
- **Error and counter wrap:**
  - Toggle `xfer_ack_i` while idle → `protocol_err_o = 1` from 2 edges after sampling, and it stays set.
  - With `CNT_WIDTH = 2`, 5 transfers → `xfer_cnt_o = 1`.
- **Reset mid-transfer:** accept 0x77, assert `rst_i` before ack → all outputs at reset values next edge. After release, a new transfer of 0x12 completes normally with `xfer_cnt_o = 1`.
